output_delta_scheduler: RTL and testbench

- Sequences the output-layer delta computation (delta = node output − expected) over all NUM_NODE output neurons of one training sample.
- Reads node/expected pairs from synchronous-read buffers and streams them one per cycle into the external 7-cycle floating-point subtract unit.
- Collects the in-order results and writes them to the delta buffer consumed by the hidden-layer back-propagation stage.
- Pulses done when all deltas have been written.

---
 rtl/output_delta_scheduler_if.sv | 39 +++
 rtl/output_delta_scheduler.sv | 130 +++++++++++++
 tb/tb_output_delta_scheduler.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/output_delta_scheduler_if.sv
// Handshake/bus bundle between the delta scheduler and its surroundings:
// node/expected read buffers, the floating-point subtract unit and the delta buffer.
interface output_delta_scheduler_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 2
);
    logic                  i_start;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_err;
    logic                  o_rd_en;
    logic [ADDR_WIDTH-1:0] o_rd_addr;
    logic [DATA_WIDTH-1:0] i_rd_node;
    logic [DATA_WIDTH-1:0] i_rd_expected;
    logic                  o_sub_valid;
    logic [DATA_WIDTH-1:0] o_sub_node;
    logic [DATA_WIDTH-1:0] o_sub_expected;
    logic                  i_sub_valid;
    logic [DATA_WIDTH-1:0] i_sub_delta;
    logic                  o_wr_en;
    logic [ADDR_WIDTH-1:0] o_wr_addr;
    logic [DATA_WIDTH-1:0] o_wr_data;

    // Scheduler side
    modport master (
        input  i_start, i_rd_node, i_rd_expected, i_sub_valid, i_sub_delta,
        output o_busy, o_done, o_err, o_rd_en, o_rd_addr,
               o_sub_valid, o_sub_node, o_sub_expected,
               o_wr_en, o_wr_addr, o_wr_data
    );

    // Environment side (buffers, subtract unit, controller)
    modport slave (
        output i_start, i_rd_node, i_rd_expected, i_sub_valid, i_sub_delta,
        input  o_busy, o_done, o_err, o_rd_en, o_rd_addr,
               o_sub_valid, o_sub_node, o_sub_expected,
               o_wr_en, o_wr_addr, o_wr_data
    );
endinterface

// File: rtl/output_delta_scheduler.sv
// Output-layer delta scheduler: reads NUM_NODE node/expected pairs, streams them
// into the external subtract unit one per cycle and writes the in-order results
// (delta = node - expected) to the delta buffer, then pulses o_done.
module output_delta_scheduler #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_NODE     = 4,
    parameter int ADDR_WIDTH   = 2,
    parameter int PIPE_LATENCY = 7
) (
    input logic                      clk,
    input logic                      rst_n,
    output_delta_scheduler_if.master bus
);
    localparam int CW = $clog2(NUM_NODE + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_NODE - 1);
    localparam logic [CW-1:0]         NODE_CNT  = CW'(NUM_NODE);

    // Parameter sanity; results are tracked by handshake so latency is only bounded here.
    if (NUM_NODE < 1 || (1 << ADDR_WIDTH) < NUM_NODE || PIPE_LATENCY < 1 ||
        $bits(bus.o_wr_data) != DATA_WIDTH || $bits(bus.o_wr_addr) != ADDR_WIDTH) begin : g_bad_cfg
        $error("output_delta_scheduler: inconsistent parameters");
    end

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t          state;
    logic            rd_en_d1;
    logic [CW-1:0]   wr_cnt;
    logic [CW-1:0]   outstanding;
    logic            accept;
    logic            res_hit;
    logic            res_spur;
    logic            wr_ovf;

    // A result is expected if one is in flight or an operand leaves this very cycle.
    assign accept   = (state == IDLE) && bus.i_start;
    assign res_hit  = bus.i_sub_valid && ((outstanding != '0) || bus.o_sub_valid);
    assign res_spur = bus.i_sub_valid && !res_hit;
    assign wr_ovf   = res_hit && (wr_cnt >= NODE_CNT);

    // Pass sequencer: issues the read burst, waits for the last write, pulses done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.o_busy    <= 1'b0;
            bus.o_done    <= 1'b0;
            bus.o_rd_en   <= 1'b0;
            bus.o_rd_addr <= '0;
        end else begin
            bus.o_done <= 1'b0;
            case (state)
                IDLE: if (bus.i_start) begin
                    state         <= READ;
                    bus.o_busy    <= 1'b1;
                    bus.o_rd_en   <= 1'b1;
                    bus.o_rd_addr <= '0;
                end
                READ: begin
                    // The read address doubles as the read counter and parks on the last node.
                    if (bus.o_rd_addr == LAST_ADDR) begin
                        bus.o_rd_en <= 1'b0;
                        state       <= DRAIN;
                    end else begin
                        bus.o_rd_addr <= bus.o_rd_addr + 1'b1;
                    end
                end
                DRAIN: if (bus.o_wr_en && bus.o_wr_addr == LAST_ADDR) begin
                    state      <= DONE;
                    bus.o_done <= 1'b1;
                    bus.o_busy <= 1'b0;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Operand stage: buffer data arrives the cycle after the read strobe; register it
    // and present it to the subtract unit with a valid aligned two cycles after o_rd_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_d1           <= 1'b0;
            bus.o_sub_valid    <= 1'b0;
            bus.o_sub_node     <= '0;
            bus.o_sub_expected <= '0;
        end else begin
            rd_en_d1        <= bus.o_rd_en;
            bus.o_sub_valid <= rd_en_d1;
            if (rd_en_d1) begin
                bus.o_sub_node     <= bus.i_rd_node;
                bus.o_sub_expected <= bus.i_rd_expected;
            end
        end
    end

    // Result stage: write in-order deltas to sequential addresses, track in-flight
    // operands and flag results that nothing asked for or that overrun the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt        <= '0;
            outstanding   <= '0;
            bus.o_err     <= 1'b0;
            bus.o_wr_en   <= 1'b0;
            bus.o_wr_addr <= '0;
            bus.o_wr_data <= '0;
        end else begin
            bus.o_wr_en <= 1'b0;
            if (accept) begin
                wr_cnt      <= '0;
                outstanding <= '0;
                bus.o_err   <= 1'b0;
            end else begin
                if (res_hit && !wr_ovf) begin
                    bus.o_wr_en   <= 1'b1;
                    bus.o_wr_addr <= ADDR_WIDTH'(wr_cnt);
                    bus.o_wr_data <= bus.i_sub_delta;
                    wr_cnt        <= wr_cnt + 1'b1;
                end
                if (res_spur || wr_ovf) begin
                    bus.o_err <= 1'b1;
                end
                case ({bus.o_sub_valid, res_hit})
                    2'b10:   outstanding <= outstanding + 1'b1;
                    2'b01:   outstanding <= outstanding - 1'b1;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_output_delta_scheduler.sv
// Bench for output_delta_scheduler: N=4 and N=1 instances, each with a behavioural
// read buffer and a 7-cycle subtract unit; expectations come from the pass timing
// rules (writes at 4+LAT+i, done at N+LAT+4) and delta = node - expected.
module tb_output_delta_scheduler;
    localparam int LAT = 7;
    localparam int N   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    output_delta_scheduler_if #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) ifc ();
    output_delta_scheduler_if #(.DATA_WIDTH(32), .ADDR_WIDTH(1)) ifc1 ();

    output_delta_scheduler #(.DATA_WIDTH(32), .NUM_NODE(N), .ADDR_WIDTH(2), .PIPE_LATENCY(LAT))
        u_dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
    output_delta_scheduler #(.DATA_WIDTH(32), .NUM_NODE(1), .ADDR_WIDTH(1), .PIPE_LATENCY(LAT))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1));

    // Values are kept as half-units (value = h/2) so every float is exact.
    function automatic logic [31:0] h2f(input int h);
        int m, p;
        logic [31:0] t;
        logic [7:0] e;
        if (h == 0) return 32'h0;
        m = (h < 0) ? -h : h;
        p = 0;
        for (int b = 30; b >= 0; b--) if (m[b]) begin p = b; break; end
        t = 32'(m) << (23 - p);
        e = 8'(126 + p);
        return {(h < 0), e, t[22:0]};
    endfunction

    function automatic int f2h(input logic [31:0] f);
        int p;
        logic [31:0] m;
        if (f[30:0] == 31'h0) return 0;
        p = int'(f[30:23]) - 126;
        m = {8'h0, 1'b1, f[22:0]} >> (23 - p);
        return f[31] ? -int'(m) : int'(m);
    endfunction

    // Buffers and subtract units
    int node_h[N], exp_h[N];
    int n1_h, e1_h;
    logic inj = 1'b0;

    always @(posedge clk) begin
        if (ifc.o_rd_en) begin
            ifc.i_rd_node     <= h2f(node_h[ifc.o_rd_addr]);
            ifc.i_rd_expected <= h2f(exp_h[ifc.o_rd_addr]);
        end
        if (ifc1.o_rd_en) begin
            ifc1.i_rd_node     <= h2f(n1_h);
            ifc1.i_rd_expected <= h2f(e1_h);
        end
    end

    logic [LAT-1:0] sv_pipe = '0, sv1_pipe = '0;
    logic [31:0] sd_pipe[LAT], sd1_pipe[LAT];
    always @(posedge clk) begin
        sv_pipe  <= {sv_pipe[LAT-2:0], ifc.o_sub_valid};
        sv1_pipe <= {sv1_pipe[LAT-2:0], ifc1.o_sub_valid};
        sd_pipe[0]  <= h2f(f2h(ifc.o_sub_node) - f2h(ifc.o_sub_expected));
        sd1_pipe[0] <= h2f(f2h(ifc1.o_sub_node) - f2h(ifc1.o_sub_expected));
        for (int i = 1; i < LAT; i++) begin
            sd_pipe[i]  <= sd_pipe[i-1];
            sd1_pipe[i] <= sd1_pipe[i-1];
        end
    end
    assign ifc.i_sub_valid  = sv_pipe[LAT-1] | inj;
    assign ifc.i_sub_delta  = sd_pipe[LAT-1];
    assign ifc1.i_sub_valid = sv1_pipe[LAT-1];
    assign ifc1.i_sub_delta = sd1_pipe[LAT-1];

    // Monitors (relative cycle = cyc - acc, rel 1 is the cycle after acceptance)
    int acc = 0;
    int rd_n, rd1_n, rd1_rel;
    int wr_rel[$], wr_addr[$], done_rel[$], wr1_rel[$], done1_rel[$];
    logic [31:0] wr_data[$], wr1_data[$];
    always @(negedge clk) if (rst_n) begin
        if (ifc.o_rd_en) rd_n++;
        if (ifc.o_wr_en) begin
            wr_rel.push_back(cyc - acc); wr_addr.push_back(int'(ifc.o_wr_addr));
            wr_data.push_back(ifc.o_wr_data);
        end
        if (ifc.o_done) done_rel.push_back(cyc - acc);
        if (ifc1.o_rd_en) begin rd1_n++; rd1_rel = cyc - acc; end
        if (ifc1.o_wr_en) begin wr1_rel.push_back(cyc - acc); wr1_data.push_back(ifc1.o_wr_data); end
        if (ifc1.o_done) done1_rel.push_back(cyc - acc);
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rd_n = 0; rd1_n = 0; rd1_rel = -1;
        wr_rel.delete(); wr_addr.delete(); wr_data.delete(); done_rel.delete();
        wr1_rel.delete(); wr1_data.delete(); done1_rel.delete();
    endtask

    task automatic randomize_vals();
        for (int i = 0; i < N; i++) begin
            node_h[i] = int'($urandom_range(400)) - 200;
            exp_h[i]  = int'($urandom_range(400)) - 200;
        end
    endtask

    task automatic wait_rel(input int r);
        while (cyc - acc < r) @(negedge clk);
    endtask

    task automatic start_pass(input bit both);
        clear_logs();
        @(negedge clk); ifc.i_start = 1'b1; ifc1.i_start = both;
        @(negedge clk); ifc.i_start = 1'b0; ifc1.i_start = 1'b0; acc = cyc - 1;
    endtask

    // Pass p of a run (passes repeat every N+LAT+5 cycles when start is held)
    task automatic check_pass(input string t, input int p);
        int base;
        base = p * (N + LAT + 5);
        for (int i = 0; i < N; i++) begin
            if (p * N + i < wr_rel.size()) begin
                chk({t, ".wr_cycle"}, 32'(wr_rel[p*N+i]), 32'(base + 4 + LAT + i));
                chk({t, ".wr_addr"}, 32'(wr_addr[p*N+i]), 32'(i));
                chk({t, ".wr_data"}, wr_data[p*N+i], h2f(node_h[i] - exp_h[i]));
            end
        end
        if (p < done_rel.size()) chk({t, ".done_cycle"}, 32'(done_rel[p]), 32'(base + N + LAT + 4));
    endtask

    task automatic check_zero(input string t);
        chk({t, ".rd_en"}, 32'(ifc.o_rd_en), 0);
        chk({t, ".busy"}, 32'(ifc.o_busy), 0);
        chk({t, ".done"}, 32'(ifc.o_done), 0);
        chk({t, ".err"}, 32'(ifc.o_err), 0);
        chk({t, ".sub_valid"}, 32'(ifc.o_sub_valid), 0);
        chk({t, ".sub_node"}, ifc.o_sub_node, 0);
        chk({t, ".wr_en"}, 32'(ifc.o_wr_en), 0);
        chk({t, ".wr_data"}, ifc.o_wr_data, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        ifc.i_start = 1'b0; ifc1.i_start = 1'b0;
        #1 check_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: directed pass on both instances
        node_h = '{2, 5, -6, 1}; exp_h = '{0, 5, 2, -1};
        n1_h = 5; e1_h = -3;
        start_pass(1'b1);
        chk("t1.busy", 32'(ifc.o_busy), 1);
        chk("t1.rd_addr0", 32'(ifc.o_rd_addr), 0);
        wait_rel(24);
        chk("t1.rd_count", 32'(rd_n), N);
        chk("t1.wr_count", 32'(wr_rel.size()), N);
        chk("t1.done_count", 32'(done_rel.size()), 1);
        check_pass("t1", 0);
        if (wr_data.size() == N) begin
            chk("t1.const0", wr_data[0], 32'h3F800000);
            chk("t1.const1", wr_data[1], 32'h00000000);
            chk("t1.const2", wr_data[2], 32'hC0800000);
            chk("t1.const3", wr_data[3], 32'h3F800000);
        end
        chk("t1.err", 32'(ifc.o_err), 0);
        chk("t1.busy_end", 32'(ifc.o_busy), 0);
        // 6: single-node instance
        chk("t6.rd_count", 32'(rd1_n), 1);
        chk("t6.rd_cycle", 32'(rd1_rel), 1);
        chk("t6.wr_count", 32'(wr1_rel.size()), 1);
        if (wr1_rel.size() > 0) begin
            chk("t6.wr_cycle", 32'(wr1_rel[0]), LAT + 4);
            chk("t6.wr_data", wr1_data[0], 32'h40800000);
        end
        chk("t6.done_count", 32'(done1_rel.size()), 1);
        if (done1_rel.size() > 0) chk("t6.done_cycle", 32'(done1_rel[0]), LAT + 5);

        // 2: start held high, two back-to-back passes
        randomize_vals();
        clear_logs();
        @(negedge clk); ifc.i_start = 1'b1;
        @(negedge clk); acc = cyc - 1;
        wait_rel(2 * (N + LAT + 5) - 1);
        ifc.i_start = 1'b0;
        wait_rel(45);
        chk("t2.rd_count", 32'(rd_n), 2 * N);
        chk("t2.wr_count", 32'(wr_rel.size()), 2 * N);
        chk("t2.done_count", 32'(done_rel.size()), 2);
        check_pass("t2a", 0);
        check_pass("t2b", 1);

        // 3: start pulses while busy are ignored
        randomize_vals();
        start_pass(1'b0);
        wait_rel(5);  ifc.i_start = 1'b1; @(negedge clk); ifc.i_start = 1'b0;
        wait_rel(12); ifc.i_start = 1'b1; @(negedge clk); ifc.i_start = 1'b0;
        wait_rel(24);
        chk("t3.rd_count", 32'(rd_n), N);
        chk("t3.wr_count", 32'(wr_rel.size()), N);
        chk("t3.done_count", 32'(done_rel.size()), 1);
        check_pass("t3", 0);

        // 4: spurious result in IDLE
        clear_logs();
        @(negedge clk); inj = 1'b1;
        @(negedge clk); inj = 1'b0;
        repeat (4) @(negedge clk);
        chk("t4.spur_wr", 32'(wr_rel.size()), 0);
        chk("t4.err_set", 32'(ifc.o_err), 1);
        randomize_vals();
        start_pass(1'b0);
        chk("t4.err_clr", 32'(ifc.o_err), 0);
        wait_rel(24);
        chk("t4.wr_count", 32'(wr_rel.size()), N);
        check_pass("t4", 0);
        chk("t4.err_end", 32'(ifc.o_err), 0);

        // 5: reset mid-pass, stale results then flag an error
        randomize_vals();
        start_pass(1'b0);
        wait_rel(8);
        rst_n = 1'b0;
        #1 check_zero("t5.rst");
        clear_logs();
        @(negedge clk); rst_n = 1'b1;
        wait_rel(22);
        chk("t5.wr_count", 32'(wr_rel.size()), 0);
        chk("t5.done_count", 32'(done_rel.size()), 0);
        chk("t5.err", 32'(ifc.o_err), 1);
        randomize_vals();
        start_pass(1'b0);
        wait_rel(24);
        chk("t5.rd_count", 32'(rd_n), N);
        chk("t5.wr_count2", 32'(wr_rel.size()), N);
        chk("t5.done_count2", 32'(done_rel.size()), 1);
        check_pass("t5", 0);
        chk("t5.err_end", 32'(ifc.o_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
